// File: rtl/seq_det_pkg.sv
// Shared types and elaboration-time helpers for the shared serial pattern detector.
// The fallback table gives the detector progress after a mismatching bit.
package seq_det_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      REPORT = 2'd2
   } sched_state_t;

   localparam int MAX_PAT = 32;

   typedef logic [5:0]                fb_t;
   typedef fb_t [2*MAX_PAT-1:0]       fb_tab_t;

   function automatic int clog2_safe(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

   // Entry 2*m+b: longest proper prefix of the pattern that ends the bits seen
   // so far, after m matched bits are followed by the mismatching bit b.
   function automatic fb_tab_t build_fallback(input logic [MAX_PAT-1:0] pat, input int len);
      fb_tab_t           tab;
      logic [MAX_PAT:0]  s;
      int                best;
      bit                ok;
      tab = '0;
      for (int m = 0; m < len; m++) begin
         for (int b = 0; b < 2; b++) begin
            s = '0;
            for (int j = 0; j < m; j++) begin
               s[j] = pat[len-1-j];
            end
            s[m] = b[0];
            best = 0;
            for (int k = 1; k <= m; k++) begin
               ok = 1'b1;
               for (int i = 0; i < k; i++) begin
                  if (pat[len-1-i] != s[m+1-k+i]) begin
                     ok = 1'b0;
                  end else begin
                     ok = ok;
                  end
               end
               if (ok) begin
                  best = k;
               end else begin
                  best = best;
               end
            end
            tab[2*m+b] = fb_t'(best);
         end
      end
      return tab;
   endfunction

endpackage

// File: rtl/seq_det_scheduler_if.sv
// Requester and result channels of the shared detector scheduler.
interface seq_det_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int ID_W    = 2,
   parameter int CNT_W   = 2
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      res_valid;
   logic                      res_ready;
   logic [ID_W-1:0]           res_id;
   logic [CNT_W-1:0]          res_count;

   modport master (
      output req_valid, req_data, res_ready,
      input  req_ready, res_valid, res_id, res_count
   );

   modport slave (
      input  req_valid, req_data, res_ready,
      output req_ready, res_valid, res_id, res_count
   );
endinterface

// File: rtl/pattern_det_serial.sv
// Bit-serial non-overlapping Mealy detector; hit is a combinational pulse on
// the bit that completes the pattern, after which progress restarts from zero.
module pattern_det_serial
   import seq_det_pkg::*;
#(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   input  logic bit_in,
   output logic hit
);
   localparam int             M_W    = clog2_safe(PAT_LEN);
   localparam logic [M_W-1:0] LAST_M = M_W'(PAT_LEN - 1);
   localparam fb_tab_t        FB_TAB = build_fallback(MAX_PAT'(PATTERN), PAT_LEN);

   logic [M_W-1:0] m_q, m_d;
   logic           exp_bit;
   logic [M_W:0]   fb_idx;

   // Progress update and match pulse for the bit presented this cycle
   always_comb begin
      hit     = 1'b0;
      m_d     = m_q;
      exp_bit = PATTERN[LAST_M - m_q];
      fb_idx  = {m_q, bit_in};
      if (en) begin
         if (bit_in == exp_bit) begin
            if (m_q == LAST_M) begin
               hit = 1'b1;
               m_d = '0;
            end else begin
               m_d = m_q + M_W'(1);
            end
         end else begin
            m_d = M_W'(FB_TAB[fb_idx]);
         end
      end else begin
         m_d = m_q;
      end
   end

   // Progress register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_q <= '0;
      end else if (clr) begin
         m_q <= '0;
      end else begin
         m_q <= m_d;
      end
   end

endmodule

// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler sharing one serial pattern detector between word-parallel
// requesters; each granted word is shifted MSB-first and its match count returned.
module seq_det_scheduler
   import seq_det_pkg::*;
#(
   parameter int                 NUM_REQ = 4,
   parameter int                 DATA_W  = 8,
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010
) (
   input  logic               clk,
   input  logic               rst_n,
   seq_det_scheduler_if.slave bus,
   output logic               busy,
   output logic               det_hit
);
   localparam int              ID_W     = clog2_safe(NUM_REQ);
   localparam int              CNT_W    = clog2_safe(DATA_W / PAT_LEN + 1);
   localparam int              BC_W     = clog2_safe(DATA_W);
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);
   localparam logic [ID_W-1:0] RR_RESET = ID_W'(NUM_REQ - 1);

   sched_state_t       state_q, state_d;
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [DATA_W-1:0]  shreg_q, shreg_d;
   logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ID_W-1:0]    id_q, id_d;

   logic               grant_found;
   logic [ID_W-1:0]    grant_idx;
   logic [NUM_REQ-1:0] ready_vec;
   logic               det_en;
   logic               det_clr;

   // Round-robin search starting just after the last served requester
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!grant_found && bus.req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
            grant_found = 1'b1;
            grant_idx   = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         end else begin
            grant_found = grant_found;
         end
      end
   end

   assign det_en  = (state_q == SHIFT);
   assign det_clr = (state_q == IDLE) && grant_found;

   pattern_det_serial #(
      .PAT_LEN (PAT_LEN),
      .PATTERN (PATTERN)
   ) u_det (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (det_clr),
      .en     (det_en),
      .bit_in (shreg_q[DATA_W-1]),
      .hit    (det_hit)
   );

   // Scheduler next-state: accept in IDLE, shift DATA_W bits, hold result until taken
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      cnt_d     = cnt_q;
      id_d      = id_q;
      ready_vec = '0;
      case (state_q)
         IDLE: begin
            if (grant_found) begin
               ready_vec[grant_idx] = 1'b1;
               shreg_d   = bus.req_data[int'(grant_idx)*DATA_W +: DATA_W];
               id_d      = grant_idx;
               cnt_d     = '0;
               bit_cnt_d = '0;
               state_d   = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BC_W'(1);
            if (det_hit) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               cnt_d = cnt_q;
            end
            if (bit_cnt_q == LAST_BIT) begin
               state_d = REPORT;
            end else begin
               state_d = SHIFT;
            end
         end
         REPORT: begin
            if (bus.res_ready) begin
               state_d  = IDLE;
               rr_ptr_d = id_q;
            end else begin
               state_d = REPORT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Scheduler state registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rr_ptr_q  <= RR_RESET;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         cnt_q     <= '0;
         id_q      <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         cnt_q     <= cnt_d;
         id_q      <= id_d;
      end
   end

   assign bus.req_ready = ready_vec;
   assign bus.res_valid = (state_q == REPORT);
   assign bus.res_id    = id_q;
   assign bus.res_count = cnt_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Randomised and directed bench for seq_det_scheduler against a transaction-level
// model: greedy non-overlapping pattern search plus round-robin grant order.
module tb_seq_det_scheduler;
   localparam int             NUM_REQ = 4;
   localparam int             DATA_W  = 8;
   localparam int             PAT_LEN = 4;
   localparam logic [3:0]     PAT     = 4'b1010;
   localparam int             ID_W    = 2;
   localparam int             CNT_W   = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic busy;
   logic det_hit;

   always #5 clk = ~clk;

   seq_det_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();

   seq_det_scheduler #(
      .NUM_REQ (NUM_REQ),
      .DATA_W  (DATA_W),
      .PAT_LEN (PAT_LEN),
      .PATTERN (PAT)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .busy    (busy),
      .det_hit (det_hit)
   );

   int n_checks;
   int n_fail;

   // stimulus state
   logic [NUM_REQ-1:0] valid_v;
   logic [DATA_W-1:0]  data_v [NUM_REQ];
   logic               rdy_v;
   logic               rst_v;

   // model state
   bit                 m_busy;
   int                 m_k;
   int                 m_id;
   int                 m_rr;
   int                 m_cnt;
   logic [DATA_W-1:0]  m_hits;
   int                 grant_log[$];
   int                 res_log[$];
   int                 last_obs_cnt;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Leftmost greedy scan; hits[k] marks the shift cycle that completes a match.
   function automatic void ref_count(input logic [DATA_W-1:0] w, output int cnt,
                                     output logic [DATA_W-1:0] hits);
      int i;
      bit ok;
      cnt  = 0;
      hits = '0;
      i    = 0;
      while (i <= DATA_W - PAT_LEN) begin
         ok = 1'b1;
         for (int t = 0; t < PAT_LEN; t++)
            if (w[DATA_W-1-i-t] != PAT[PAT_LEN-1-t]) ok = 1'b0;
         if (ok) begin
            cnt++;
            hits[i+PAT_LEN-1] = 1'b1;
            i += PAT_LEN;
         end else begin
            i++;
         end
      end
   endfunction

   task automatic step();
      logic [NUM_REQ-1:0] exp_rdy;
      int  g;
      bit  acc, done;
      rst_n         = rst_v;
      bus.req_valid = valid_v;
      bus.res_ready = rdy_v;
      for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*DATA_W +: DATA_W] = data_v[i];
      #1;
      acc = 1'b0;
      done = 1'b0;
      exp_rdy = '0;
      g = -1;
      if (rst_v) begin
         if (!m_busy) begin
            for (int o = 1; o <= NUM_REQ; o++)
               if (g < 0 && valid_v[(m_rr + o) % NUM_REQ]) g = (m_rr + o) % NUM_REQ;
            if (g >= 0) exp_rdy[g] = 1'b1;
            check_eq("idle_req_ready", bus.req_ready, exp_rdy);
            check_eq("idle_busy", busy, 1'b0);
            check_eq("idle_res_valid", bus.res_valid, 1'b0);
            check_eq("idle_det_hit", det_hit, 1'b0);
            acc = (g >= 0);
         end else if (m_k < DATA_W) begin
            check_eq("shift_req_ready", bus.req_ready, '0);
            check_eq("shift_busy", busy, 1'b1);
            check_eq("shift_res_valid", bus.res_valid, 1'b0);
            check_eq("shift_det_hit", det_hit, m_hits[m_k]);
         end else begin
            check_eq("rep_res_valid", bus.res_valid, 1'b1);
            check_eq("rep_res_id", bus.res_id, m_id);
            check_eq("rep_res_count", bus.res_count, m_cnt);
            check_eq("rep_req_ready", bus.req_ready, '0);
            check_eq("rep_busy", busy, 1'b1);
            done = rdy_v;
            if (done) last_obs_cnt = int'(bus.res_count);
         end
      end
      @(posedge clk);
      #1;
      if (!rst_v) begin
         m_busy = 1'b0;
         m_rr   = NUM_REQ - 1;
      end else if (acc) begin
         m_busy = 1'b1;
         m_k    = 0;
         m_id   = g;
         ref_count(data_v[g], m_cnt, m_hits);
         grant_log.push_back(g);
      end else if (m_busy && m_k < DATA_W) begin
         m_k++;
      end else if (done) begin
         m_busy = 1'b0;
         m_rr   = m_id;
         res_log.push_back(m_id);
      end
   endtask

   task automatic wait_grants(input int n, input int budget);
      int target;
      int c;
      target = grant_log.size() + n;
      c = 0;
      while (grant_log.size() < target && c < budget) begin
         step();
         c++;
      end
      check_eq("grant_wait", grant_log.size() >= target, 1'b1);
   endtask

   task automatic drain();
      int c;
      c = 0;
      while (m_busy && c < 100) begin
         step();
         c++;
      end
      check_eq("drain_wait", m_busy, 1'b0);
   endtask

   task automatic send_word(input int id, input logic [DATA_W-1:0] w);
      valid_v[id] = 1'b1;
      data_v[id]  = w;
      wait_grants(1, 20);
      check_eq("send_grant_id", grant_log[$], id);
      valid_v[id] = 1'b0;
      drain();
   endtask

   function automatic int count_id(input int id);
      int n;
      n = 0;
      foreach (grant_log[i]) if (grant_log[i] == id) n++;
      return n;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int n1;
      int nres;
      n_checks = 0;
      n_fail   = 0;
      valid_v  = '0;
      rdy_v    = 1'b1;
      rst_v    = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) data_v[i] = '0;
      m_busy = 1'b0;
      m_rr   = NUM_REQ - 1;
      m_k    = 0;
      m_id   = 0;
      m_cnt  = 0;
      m_hits = '0;
      last_obs_cnt = -1;

      step();
      step();
      check_eq("rst_res_valid", bus.res_valid, 1'b0);
      check_eq("rst_res_id", bus.res_id, '0);
      check_eq("rst_res_count", bus.res_count, '0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_req_ready", bus.req_ready, '0);
      check_eq("rst_det_hit", det_hit, 1'b0);
      rst_v = 1'b1;

      send_word(0, 8'hAA);
      check_eq("cnt_AA", last_obs_cnt, 2);
      send_word(0, 8'b0101_0100);
      check_eq("cnt_54_nonoverlap", last_obs_cnt, 1);
      send_word(0, 8'b1101_0100);
      check_eq("cnt_D4", last_obs_cnt, 1);
      send_word(0, 8'h00);
      check_eq("cnt_00", last_obs_cnt, 0);

      // backpressure in REPORT
      valid_v[0] = 1'b1;
      data_v[0]  = 8'h5A;
      wait_grants(1, 20);
      valid_v[0] = 1'b0;
      rdy_v      = 1'b0;
      repeat (DATA_W) step();
      nres = res_log.size();
      repeat (5) step();
      check_eq("bp_hold", res_log.size(), nres);
      rdy_v = 1'b1;
      step();
      check_eq("bp_complete", res_log.size(), nres + 1);
      check_eq("bp_cnt", last_obs_cnt, 1);

      // all requesters continuously valid after reset
      rst_v = 1'b0;
      step();
      rst_v = 1'b1;
      valid_v = '1;
      data_v[0] = 8'hAA;
      data_v[1] = 8'h54;
      data_v[2] = 8'hD4;
      data_v[3] = 8'h0F;
      base = grant_log.size();
      wait_grants(5, 100);
      for (int i = 0; i < 5; i++) check_eq("rr_order", grant_log[base + i], i % NUM_REQ);
      valid_v = '0;
      drain();

      // reset in shift cycle 4
      valid_v[2] = 1'b1;
      wait_grants(1, 40);
      check_eq("pre_rst_grant", grant_log[$], 2);
      repeat (4) step();
      rst_v = 1'b0;
      step();
      rst_v = 1'b1;
      check_eq("mid_rst_busy", busy, 1'b0);
      check_eq("mid_rst_res_valid", bus.res_valid, 1'b0);
      valid_v = 4'b0101;
      base = grant_log.size();
      step();
      check_eq("post_rst_grant_made", grant_log.size(), base + 1);
      check_eq("post_rst_grant", grant_log[$], 0);
      valid_v = '0;
      drain();

      // requester 1 drops its request during another's shift
      n1 = count_id(1);
      valid_v[0] = 1'b1;
      data_v[0]  = 8'hAA;
      wait_grants(1, 20);
      valid_v[0] = 1'b0;
      step();
      valid_v[1] = 1'b1;
      repeat (3) step();
      valid_v[1] = 1'b0;
      drain();
      repeat (3) step();
      check_eq("drop_no_grant", count_id(1), n1);
      check_eq("drop_res_id", res_log[$], 0);

      // randomised traffic
      nres = res_log.size();
      repeat (1500) begin
         valid_v = NUM_REQ'($urandom_range(0, 15));
         for (int i = 0; i < NUM_REQ; i++) data_v[i] = DATA_W'($urandom);
         rdy_v = ($urandom_range(0, 3) != 0);
         step();
      end
      valid_v = '0;
      rdy_v   = 1'b1;
      drain();
      check_eq("rand_progress", res_log.size() > nres + 20, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
